moving_sum_filter: RTL

Parametrised sliding-window accumulator: sums the last TAPS accepted samples of a streaming input and produces a registered running sum plus a shifted average each time a sample is accepted. It generalises the fixed 5-tap, 8-bit unsigned filter to configurable data width, window depth, signedness and averaging. It adds a valid handshake, a synchronous flush and window-fill status. It sits between a sample source (ADC or decimator front end) and downstream detection logic.

---
 rtl/moving_sum_filter.sv | 79 +++++++
 1 files changed

// File: rtl/moving_sum_filter.sv
// rtl/moving_sum_filter.sv - sliding-window running sum and shifted average over the last TAPS samples
// The running sum is updated incrementally: add the new sample, subtract the one it overwrites.
module moving_sum_filter #(
   parameter int DATA_W    = 8,
   parameter int TAPS      = 5,
   parameter int SUM_W     = 12,
   parameter int SIGNED    = 0,
   parameter int AVG_SHIFT = 0,
   localparam int FILL_W   = $clog2(TAPS + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   output logic [SUM_W-1:0]  out_sum,
   output logic [SUM_W-1:0]  out_avg,
   output logic [FILL_W-1:0] fill,
   output logic              primed
);

   localparam int PTR_W = $clog2(TAPS);
   localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(TAPS - 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(TAPS);

   logic [DATA_W-1:0] window_q [TAPS];
   logic [PTR_W-1:0]  ptr_q;
   logic [FILL_W-1:0] fill_q;
   logic [SUM_W-1:0]  sum_q;
   logic              valid_q;
   logic [SUM_W-1:0]  sum_next;

   function automatic logic [SUM_W-1:0] ext(input logic [DATA_W-1:0] d);
      if (SIGNED != 0)
         return {{(SUM_W - DATA_W){d[DATA_W-1]}}, d};
      else
         return {{(SUM_W - DATA_W){1'b0}}, d};
   endfunction

   // The entry at the write pointer is the oldest sample (or 0 if never written).
   assign sum_next = sum_q + ext(in_data) - ext(window_q[ptr_q]);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         for (int i = 0; i < TAPS; i++)
            window_q[i] <= '0;
         ptr_q   <= '0;
         fill_q  <= '0;
         sum_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= in_valid;
         if (in_valid) begin
            window_q[ptr_q] <= in_data;
            sum_q           <= sum_next;
            ptr_q           <= (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
            if (fill_q != FILL_FULL)
               fill_q <= fill_q + 1'b1;
         end
      end
   end

   generate
      if (SIGNED != 0) begin : g_avg_signed
         logic signed [SUM_W-1:0] avg_s;
         assign avg_s   = $signed(sum_q) >>> AVG_SHIFT;
         assign out_avg = $unsigned(avg_s);
      end else begin : g_avg_unsigned
         assign out_avg = sum_q >> AVG_SHIFT;
      end
   endgenerate

   assign out_valid = valid_q;
   assign out_sum   = sum_q;
   assign fill      = fill_q;
   assign primed    = (fill_q == FILL_FULL);

endmodule
